// File: rtl/lzss_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lzss_pkg
// Brief    : Shared sizing helpers, FSM states and token builders for the
//            LZSS stream encoder.
// Revision : 1.0 - initial release
// ============================================================================
package lzss_pkg;

   localparam int MIN_MATCH = 2;

   typedef logic [1:0] state_t;

   localparam state_t ST_RUN     = 2'd0;
   localparam state_t ST_RESTART = 2'd1;
   localparam state_t ST_FLUSH   = 2'd2;

   function automatic int off_bits(input int window);
      return $clog2(window);
   endfunction

   function automatic int pay_w(input int word, input int offb, input int lenb);
      return (word > offb + lenb) ? word : offb + lenb;
   endfunction

   function automatic int tok_w(input int payw);
      return payw + 1;
   endfunction

   // Flag bit is zero because only the byte bits are ever populated.
   function automatic logic [63:0] lit_token(input logic [63:0] b);
      return b;
   endfunction

   function automatic logic [63:0] ref_token(input int payw, input int lenb,
                                             input logic [31:0] off,
                                             input logic [31:0] len);
      return (64'd1 << payw) | (64'(off) << lenb) | 64'(len);
   endfunction

endpackage
`default_nettype wire

// File: rtl/lzss_match_window.sv
`default_nettype none
// ============================================================================
// Module   : lzss_match_window
// Brief    : History shift register with per-entry valid, byte compare vector
//            and lowest-index priority encoder.
// Revision : 1.0 - initial release
// ============================================================================
module lzss_match_window #(
   parameter int WORD_SIZE   = 8,
   parameter int WINDOW_SIZE = 32,
   parameter int OFF_BITS    = 5
)(
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   shift_en,
   input  logic                   clear,
   input  logic [WORD_SIZE-1:0]   byte_in,
   output logic [WINDOW_SIZE-1:0] hit,
   input  logic [WINDOW_SIZE-1:0] prio_vec,
   output logic [OFF_BITS-1:0]    prio_idx,
   output logic                   prio_any
);

   logic [WORD_SIZE-1:0]   r_hist [WINDOW_SIZE];
   logic [WINDOW_SIZE-1:0] r_hvalid;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_hvalid <= '0;
         for (int i = 0; i < WINDOW_SIZE; i++) begin
            r_hist[i] <= '0;
         end
      end else begin
         if (shift_en) begin
            r_hist[0] <= byte_in;
            for (int i = 1; i < WINDOW_SIZE; i++) begin
               r_hist[i] <= r_hist[i-1];
            end
            r_hvalid <= {r_hvalid[WINDOW_SIZE-2:0], 1'b1};
         end
         // Frame end wins over a same-cycle shift so no match spans frames.
         if (clear) begin
            r_hvalid <= '0;
         end
      end
   end

   generate
      for (genvar gi = 0; gi < WINDOW_SIZE; gi++) begin : g_hit
         assign hit[gi] = r_hvalid[gi] && (r_hist[gi] == byte_in);
      end
   endgenerate

   always_comb begin
      prio_idx = '0;
      prio_any = 1'b0;
      for (int i = WINDOW_SIZE - 1; i >= 0; i--) begin
         if (prio_vec[i]) begin
            prio_idx = OFF_BITS'(i);
            prio_any = 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/lzss_stream_encoder.sv
`default_nettype none
// ============================================================================
// Module   : lzss_stream_encoder
// Brief    : Streaming greedy LZSS compressor with valid/ready on both sides
//            and frame-delimited history.
// Revision : 1.0 - initial release
// ============================================================================
module lzss_stream_encoder
   import lzss_pkg::*;
#(
   parameter int    WORD_SIZE   = 8,
   parameter int    WINDOW_SIZE = 32,
   parameter int    LEN_BITS    = 4,
   localparam int   OFF_BITS    = off_bits(WINDOW_SIZE),
   localparam int   PAY_W       = pay_w(WORD_SIZE, OFF_BITS, LEN_BITS),
   localparam int   TOK_W       = tok_w(PAY_W)
)(
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 s_valid,
   output logic                 s_ready,
   input  logic [WORD_SIZE-1:0] s_data,
   input  logic                 s_last,
   output logic                 m_valid,
   input  logic                 m_ready,
   output logic [TOK_W-1:0]     m_data,
   output logic                 m_last
);

   localparam logic [LEN_BITS-1:0] LEN_MAX = '1;
   localparam logic [LEN_BITS-1:0] LEN_ONE = LEN_BITS'(1);

   state_t                 r_state;
   logic [LEN_BITS-1:0]    r_len;
   logic [WINDOW_SIZE-1:0] r_cand;
   logic [WORD_SIZE-1:0]   r_first;
   logic [WORD_SIZE-1:0]   r_hold;
   logic                   r_hold_last;
   logic                   r_m_valid;
   logic [TOK_W-1:0]       r_m_data;
   logic                   r_m_last;

   logic                   w_out_free;
   logic                   w_accept;
   logic [WORD_SIZE-1:0]   w_byte;
   logic [WINDOW_SIZE-1:0] w_hit;
   logic                   w_any_hit;
   logic [WINDOW_SIZE-1:0] w_cont;
   logic                   w_extend;
   logic [OFF_BITS-1:0]    w_prio_idx;
   logic                   w_prio_any;
   logic [TOK_W-1:0]       w_lit_tok;
   logic [TOK_W-1:0]       w_close_tok;

   state_t                 w_nxt_state;
   logic [LEN_BITS-1:0]    w_nxt_len;
   logic [WINDOW_SIZE-1:0] w_nxt_cand;
   logic [WORD_SIZE-1:0]   w_nxt_first;
   logic [WORD_SIZE-1:0]   w_nxt_hold;
   logic                   w_nxt_hold_last;
   logic                   w_emit;
   logic [TOK_W-1:0]       w_emit_tok;
   logic                   w_emit_last;
   logic                   w_shift;
   logic                   w_clear;

   assign w_out_free = !r_m_valid || m_ready;
   assign s_ready    = rst_n && (r_state == ST_RUN) && w_out_free;
   assign w_accept   = s_valid && s_ready;

   // RESTART replays the terminating byte against the unshifted history.
   assign w_byte     = (r_state == ST_RESTART) ? r_hold : s_data;
   assign w_any_hit  = |w_hit;
   assign w_cont     = r_cand & w_hit;
   assign w_extend   = (|w_cont) && (r_len != LEN_MAX);

   assign w_lit_tok   = TOK_W'(lit_token(64'(w_byte)));
   assign w_close_tok = ((32'(r_len) >= MIN_MATCH) && w_prio_any)
                      ? TOK_W'(ref_token(PAY_W, LEN_BITS, 32'(w_prio_idx), 32'(r_len)))
                      : TOK_W'(lit_token(64'(r_first)));

   lzss_match_window #(
      .WORD_SIZE   (WORD_SIZE),
      .WINDOW_SIZE (WINDOW_SIZE),
      .OFF_BITS    (OFF_BITS)
   ) u_window (
      .clk      (clk),
      .rst_n    (rst_n),
      .shift_en (w_shift),
      .clear    (w_clear),
      .byte_in  (w_byte),
      .hit      (w_hit),
      .prio_vec (r_cand),
      .prio_idx (w_prio_idx),
      .prio_any (w_prio_any)
   );

   always_comb begin
      w_nxt_state     = r_state;
      w_nxt_len       = r_len;
      w_nxt_cand      = r_cand;
      w_nxt_first     = r_first;
      w_nxt_hold      = r_hold;
      w_nxt_hold_last = r_hold_last;
      w_emit          = 1'b0;
      w_emit_tok      = w_lit_tok;
      w_emit_last     = 1'b0;
      w_shift         = 1'b0;
      w_clear         = 1'b0;

      case (r_state)
         ST_RUN: begin
            if (w_accept) begin
               if (r_len == '0) begin
                  w_shift = 1'b1;
                  if (w_any_hit) begin
                     w_nxt_cand  = w_hit;
                     w_nxt_len   = LEN_ONE;
                     w_nxt_first = s_data;
                     if (s_last) begin
                        w_nxt_state = ST_FLUSH;
                     end
                  end else begin
                     w_emit      = 1'b1;
                     w_emit_last = s_last;
                     w_clear     = s_last;
                  end
               end else if (w_extend) begin
                  w_nxt_cand = w_cont;
                  w_nxt_len  = r_len + LEN_ONE;
                  w_shift    = 1'b1;
                  if (s_last) begin
                     w_nxt_state = ST_FLUSH;
                  end
               end else begin
                  w_emit          = 1'b1;
                  w_emit_tok      = w_close_tok;
                  w_nxt_hold      = s_data;
                  w_nxt_hold_last = s_last;
                  w_nxt_len       = '0;
                  w_nxt_cand      = '0;
                  w_nxt_state     = ST_RESTART;
               end
            end
         end
         ST_RESTART: begin
            if (w_out_free) begin
               w_shift = 1'b1;
               if (w_any_hit) begin
                  w_nxt_cand  = w_hit;
                  w_nxt_len   = LEN_ONE;
                  w_nxt_first = r_hold;
                  w_nxt_state = r_hold_last ? ST_FLUSH : ST_RUN;
               end else begin
                  w_emit      = 1'b1;
                  w_emit_last = r_hold_last;
                  w_clear     = r_hold_last;
                  w_nxt_state = ST_RUN;
               end
            end
         end
         ST_FLUSH: begin
            if (w_out_free) begin
               w_emit      = 1'b1;
               w_emit_tok  = w_close_tok;
               w_emit_last = 1'b1;
               w_clear     = 1'b1;
               w_nxt_state = ST_RUN;
            end
         end
         default: begin
            w_nxt_state = ST_RUN;
         end
      endcase

      if (w_clear) begin
         w_nxt_len  = '0;
         w_nxt_cand = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state     <= ST_RUN;
         r_len       <= '0;
         r_cand      <= '0;
         r_first     <= '0;
         r_hold      <= '0;
         r_hold_last <= 1'b0;
         r_m_valid   <= 1'b0;
         r_m_data    <= '0;
         r_m_last    <= 1'b0;
      end else begin
         r_state     <= w_nxt_state;
         r_len       <= w_nxt_len;
         r_cand      <= w_nxt_cand;
         r_first     <= w_nxt_first;
         r_hold      <= w_nxt_hold;
         r_hold_last <= w_nxt_hold_last;
         // Emission only happens with a free slot, so a stalled token holds.
         if (w_emit) begin
            r_m_valid <= 1'b1;
            r_m_data  <= w_emit_tok;
            r_m_last  <= w_emit_last;
         end else if (m_ready) begin
            r_m_valid <= 1'b0;
         end
      end
   end

   assign m_valid = r_m_valid;
   assign m_data  = r_m_data;
   assign m_last  = r_m_last;

endmodule
`default_nettype wire

// File: tb/tb_lzss_stream_encoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_lzss_stream_encoder
// Brief    : Directed and randomized checks of the LZSS encoder against a
//            greedy-parse reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lzss_stream_encoder;

   localparam int W    = 32;
   localparam int MAXL = 15;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       s_valid = 1'b0;
   logic       s_last = 1'b0;
   logic [7:0] s_data = 8'h00;
   logic       m_ready = 1'b1;
   logic       s_ready;
   logic       m_valid;
   logic       m_last;
   logic [9:0] m_data;

   int checks = 0;
   int errors = 0;
   bit bp_en = 1'b0;
   bit stall_arm = 1'b0;
   int hold_lo = 0;
   bit stalled = 1'b0;
   logic [10:0] stall_tok = '0;

   logic [7:0]  frm[$];
   logic [10:0] exp_q[$];
   logic [10:0] got_q[$];

   always #5 clk = ~clk;

   lzss_stream_encoder dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .s_valid (s_valid),
      .s_ready (s_ready),
      .s_data  (s_data),
      .s_last  (s_last),
      .m_valid (m_valid),
      .m_ready (m_ready),
      .m_data  (m_data),
      .m_last  (m_last)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   // Collect handshaked tokens; while stalled the token must not move.
   always @(negedge clk) begin
      if (rst_n && m_valid) begin
         if (m_ready) begin
            got_q.push_back({m_last, m_data});
            stalled = 1'b0;
         end else begin
            check("s_ready_low_in_stall", 32'(s_ready), 32'd0);
            if (stalled) check("stall_stable", 32'({m_last, m_data}), 32'(stall_tok));
            stall_tok = {m_last, m_data};
            stalled   = 1'b1;
         end
      end else begin
         stalled = 1'b0;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic upd_mready();
      if (stall_arm && m_valid) begin
         stall_arm = 1'b0;
         hold_lo   = 5;
      end
      if (hold_lo > 0) begin
         m_ready = 1'b0;
         hold_lo--;
      end else begin
         m_ready = bp_en ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      upd_mready();
   endtask

   task automatic send_frame(input bit with_last, output int waits);
      waits = 0;
      for (int i = 0; i < frm.size(); i++) begin
         bit acc;
         int guard;
         guard   = 0;
         s_valid = 1'b1;
         s_data  = frm[i];
         s_last  = with_last && (i == frm.size() - 1);
         do begin
            @(posedge clk);
            acc = s_ready;
            #1;
            upd_mready();
            if (!acc) waits++;
            guard++;
         end while (!acc && guard < 100);
         if (!acc) check("accept_timeout", 32'd0, 32'd1);
      end
      s_valid = 1'b0;
      s_last  = 1'b0;
   endtask

   task automatic drain();
      int g;
      g = 0;
      while (got_q.size() < exp_q.size() && g < 300) begin
         tick();
         g++;
      end
      repeat (4) tick();
   endtask

   task automatic compare(input string tag);
      check({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         check($sformatf("%s_tok%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
      end
      got_q.delete();
      exp_q.delete();
   endtask

   // Distances d (bit d) whose byte, d positions back in this frame, equals frm[q].
   function automatic logic [32:0] hits(input int q);
      logic [32:0] h;
      h = '0;
      for (int d = 1; d <= W; d++) begin
         if (d <= q && frm[q-d] == frm[q]) h[d] = 1'b1;
      end
      return h;
   endfunction

   // Greedy nearest-offset parse of the whole frame.
   function automatic void model();
      int n;
      int p;
      n = frm.size();
      p = 0;
      exp_q.delete();
      while (p < n) begin
         logic [32:0] c;
         c = hits(p);
         if (c == '0) begin
            exp_q.push_back({p == n - 1, 10'(frm[p])});
            p++;
         end else begin
            int len;
            int q;
            int d;
            len = 1;
            q   = p + 1;
            d   = 0;
            while (q < n && len < MAXL && (c & hits(q)) != '0) begin
               c = c & hits(q);
               len++;
               q++;
            end
            for (int k = W; k >= 1; k--) if (c[k]) d = k;
            if (len == 1) exp_q.push_back({q == n, 10'(frm[p])});
            else          exp_q.push_back({q == n, 10'(32'h200 + (d - 1) * 16 + len)});
            p = q;
         end
      end
   endfunction

   initial begin
      int waits;

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_s_ready", 32'(s_ready), 32'd0);
      check("rst_m_valid", 32'(m_valid), 32'd0);
      check("rst_m_data",  32'(m_data),  32'd0);
      check("rst_m_last",  32'(m_last),  32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      check("post_rst_s_ready", 32'(s_ready), 32'd1);
      @(posedge clk);
      #1;

      // Scenario 1: plain literals, no backpressure from the encoder
      frm = '{8'h41, 8'h42, 8'h43};
      exp_q = '{11'h041, 11'h042, 11'h443};
      send_frame(1'b1, waits);
      check("s1_no_wait", 32'(waits), 32'd0);
      drain();
      compare("s1");

      // Scenario 2: reference closed by the frame end
      frm = '{8'h41, 8'h42, 8'h41, 8'h42};
      exp_q = '{11'h041, 11'h042, 11'h612};
      send_frame(1'b1, waits);
      drain();
      compare("s2");

      // Scenario 3: length saturation then restart
      frm.delete();
      repeat (17) frm.push_back(8'h00);
      exp_q = '{11'h000, 11'h20F, 11'h400};
      send_frame(1'b1, waits);
      drain();
      compare("s3");

      // Scenario 4: scenario 2 with a 5-cycle sink stall after the first token
      frm = '{8'h41, 8'h42, 8'h41, 8'h42};
      exp_q = '{11'h041, 11'h042, 11'h612};
      stall_arm = 1'b1;
      send_frame(1'b1, waits);
      check("s4_stalled_input", 32'(waits >= 5), 32'd1);
      drain();
      compare("s4");

      // Scenario 5: history does not cross frames
      frm = '{8'h41, 8'h42};
      exp_q = '{11'h041, 11'h442};
      send_frame(1'b1, waits);
      drain();
      compare("s5a");
      exp_q = '{11'h041, 11'h442};
      send_frame(1'b1, waits);
      drain();
      compare("s5b");

      // Scenario 6: reset while a match is open drops it silently
      frm = '{8'h41, 8'h42, 8'h41};
      exp_q = '{11'h041, 11'h042};
      send_frame(1'b0, waits);
      drain();
      compare("s6a");
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      @(negedge clk);
      check("s6_m_valid_after_rst", 32'(m_valid), 32'd0);
      @(posedge clk);
      #1;
      frm = '{8'h41, 8'h42};
      exp_q = '{11'h041, 11'h442};
      send_frame(1'b1, waits);
      drain();
      compare("s6b");

      // Randomized frames against the reference model, with and without backpressure
      for (int f = 0; f < 40; f++) begin
         int n;
         int mode;
         n    = $urandom_range(1, 70);
         mode = $urandom_range(0, 2);
         frm.delete();
         for (int i = 0; i < n; i++) begin
            case (mode)
               0:       frm.push_back(8'($urandom_range(0, 1)));
               1:       frm.push_back(8'($urandom_range(0, 7)));
               default: frm.push_back(8'($urandom_range(0, 255)));
            endcase
         end
         bp_en = (f % 2) == 1;
         model();
         send_frame(1'b1, waits);
         drain();
         compare($sformatf("rand%0d", f));
      end
      bp_en = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/lzss_stream_encoder.md
# lzss_stream_encoder

Parametrised, streaming LZSS compressor with valid/ready handshakes on both sides, a configurable window and length field, nearest-offset greedy matching, and frame-delimited history. It sits between the raw byte source and the bit packer in the compression datapath. It generalises the fixed 3-stage encoder with three additions: backpressure, end-of-frame flush with `m_last`, and an explicit, fully specified token format.

## Interface
- `WORD_SIZE`, 8: literal width.
- `WINDOW_SIZE`, 32: history depth (power of 2). `OFF_BITS = $clog2(WINDOW_SIZE)`.
- `LEN_BITS`, 4: length field width. `MAX_LEN = 2**LEN_BITS-1`. `MIN_MATCH = 2` is fixed.
- `PAY_W` (derived) = max(`WORD_SIZE`, `OFF_BITS+LEN_BITS`). `TOK_W = PAY_W+1`.

Ports:
- `clk` in 1: clock.
- `rst_n` in 1: reset, synchronous, active-low.
- `s_valid` in 1 / `s_ready` out 1 / `s_data` in `WORD_SIZE` / `s_last` in 1: input byte stream. `s_last` marks the final byte of a frame.
- `m_valid` out 1 / `m_ready` in 1 / `m_data` out `TOK_W` / `m_last` out 1: token stream.

## Operation
- **History.** `H[0..W-1]`, where `H[0]` is the newest byte, plus per-entry `hvalid`. A shift inserts a byte at `H[0]` and sets `hvalid[0]`.
- **Offset.** Distance `d` runs 1..W. On an incoming byte `b`: `hit[d] = hvalid[d-1] && H[d-1]==b`, evaluated against the pre-shift history. Overlapping matches (`d < len`) are legal.
- **Match state.** Candidate vector `cand[1..W]`, `len` in 0..`MAX_LEN`, and `first` (first byte of the open match).
- **Tokens.**
  - Literal: `{1'b0, zero-ext b}`.
  - Reference: `{1'b1, zero-ext {d-1 [OFF_BITS], len [LEN_BITS]}}`, where `d` is the lowest set index of `cand` (nearest match).
  - "Close" token for an open match: if `len==1`, emit literal `first`; if `len>=2`, emit a reference.
- **FSM states: RUN, RESTART, FLUSH.** `s_ready = (state==RUN) && (!m_valid || m_ready)`.
- **RUN**, on accept:
  - `len==0`: if any `hit`, set `cand=hit`, `len=1`, `first=b`, and emit nothing. Otherwise emit literal `b`. Shift `b` in either way.
  - `len>0`: compute `cont = cand & hit`. If `|cont && len<MAX_LEN`, set `cand=cont`, `len++`, and shift `b`. Otherwise emit the close token, latch `hold=b` and `hold_last=s_last`, do not shift, and go to RESTART.
  - `s_last` accepted, no termination, `len>0` afterwards: go to FLUSH.
  - `s_last` accepted, no termination, literal emitted: that literal carries `m_last`, and the frame ends.
- **RESTART**, when the output slot is free: process `hold` with the `len==0` rule above, then shift it in. If `hold_last` is set:
  - if a literal was emitted, it carries `m_last` and the frame ends;
  - otherwise go to FLUSH.
  - In all cases, return to RUN unless FLUSH was taken.
- **FLUSH**, when the output slot is free: emit the close token with `m_last=1`, the frame ends, and go to RUN.
- **Frame end.** Clear all `hvalid`, set `len=0`, clear `cand`. No match ever spans frames.

## Timing
- **Reset values.** `m_valid=0`, `m_data=0`, `m_last=0`, `hvalid=0`, `len=0`, state RUN. `s_ready` is 0 while `rst_n` is low and 1 on the first cycle after.
- **Output register.** `m_data`/`m_last`/`m_valid` are registered. A token is visible the cycle after the causing edge. While `m_valid && !m_ready`, `m_data`/`m_last` hold stable.
- **Throughput.** One byte per cycle during literal runs and match extension. Each match termination costs one extra cycle (RESTART). Each frame end with an open match costs one extra cycle (FLUSH).
- **Match length boundary.** `len==MAX_LEN` forces termination on the next byte, even if it would have matched.
- **Reset mid-frame.** Open-match state and history are discarded, and no close token is emitted.
- **Simultaneous events.** `s_last` on a terminating byte uses the RESTART-then-FLUSH path, and only the final token carries `m_last`.

## Structure
- Package `lzss_pkg`: `OFF_BITS`, `PAY_W`, `TOK_W` functions; the `MIN_MATCH` constant; the FSM state enum; literal and reference token-builder functions.
- Sub-module `lzss_match_window`: history shift register, `hvalid`, the `hit` compare vector, and the lowest-index priority encoder (`d-1`, any-flag).
- Top level: FSM, `cand`/`len`/`first`/`hold`, and the output register.

## Test plan
All scenarios use the default parameters (`TOK_W=10`).
1. Frame `41 42 43` (`s_last` on `43`) -> tokens `041`, `042`, `043`; `m_last` on `043`; `s_ready` never drops.
2. Frame `41 42 41 42` -> `041`, `042`, `212` (offset field 1, length 2); `m_last` on `212`.
3. 17 × `00` -> `000`, `20F` (length 15), then RESTART (`s_ready` low one cycle), then literal `000` with `m_last`.
4. Scenario 2 with `m_ready` held low for 5 cycles after the first token -> `s_ready` low throughout, `m_data` stable, identical token sequence.
5. Frame `41 42` followed by frame `41 42` -> the second frame emits literals `041`, `042` only (history cleared).
6. Send `41 42 41` (match open), pulse `rst_n` low for one cycle, then frame `41 42` -> no close token, and `041`, `042` with `m_last` on `042`.
